// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   Takes bytes from the TRNG byte collector and sends each one on a UART TX
//   line as an 8N1 frame: start bit, 8 data bits LSB first, stop bit.
//   A one-byte holding register sits in front of the shifter. The collector
//   samples tx_rdy one cycle before it pulses data_vld, and this register
//   absorbs that lag.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   IDLE_LEVEL    txd level in idle and during the stop bit
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   data_in   byte to send, sampled only when data_vld=1
//   data_vld  single-cycle strobe qualifying data_in
//   tx_rdy    holding register empty; upstream may strobe
//   txd       registered serial output
//   busy      a frame is in progress
//   overrun   sticky: a strobe was dropped because the hold was full
module uart_tx_byte #(
  parameter int   CLKS_PER_BIT = 434,
  parameter logic IDLE_LEVEL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_vld,
  output logic       tx_rdy,
  output logic       txd,
  output logic       busy,
  output logic       overrun
);

  localparam int            CW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shifter;
  logic [7:0]    hold_data;
  logic          hold_full;

  logic bit_end;
  logic xfer;
  logic accept;
  logic drop;

  assign bit_end = (baud_cnt == CNT_MAX);

  // The hold moves into the shifter when the line is idle, or on the last
  // cycle of a stop bit so that back-to-back frames have no idle gap.
  assign xfer   = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));
  // A strobe is still accepted when the hold is full, provided the hold is
  // emptied on the same edge.
  assign accept = data_vld && (!hold_full || xfer);
  assign drop   = data_vld && hold_full && !xfer;

  assign tx_rdy = !hold_full;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shifter   <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
      txd       <= IDLE_LEVEL;
    end else begin
      // Holding register. An accept takes priority over the transfer clear,
      // which lets the hold be refilled on the edge it drains.
      if (accept) begin
        hold_data <= data_in;
        hold_full <= 1'b1;
      end else if (xfer) begin
        hold_full <= 1'b0;
      end
      if (drop) overrun <= 1'b1;

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (xfer) begin
            shifter <= hold_data;
            state   <= START;
            txd     <= !IDLE_LEVEL;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            txd      <= shifter[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= IDLE_LEVEL;
            end else begin
              // shifter[0] is on the line now; the next bit is shifter[1].
              shifter <= shifter >> 1;
              txd     <= shifter[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (xfer) begin
              shifter <= hold_data;
              state   <= START;
              txd     <= !IDLE_LEVEL;
            end else begin
              state <= IDLE;
              txd   <= IDLE_LEVEL;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          txd      <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// Bench for uart_tx_byte with CLKS_PER_BIT=4.
// The reference model tracks time as an edge count. It holds the byte in
// flight, the time its frame started and ended, and the hold contents. The
// line level it expects is derived from the bit position (elapsed/C) within
// the frame. Outputs are compared on every falling edge.
module tb_uart_tx_byte;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_vld;
  logic       tx_rdy, txd, busy, overrun;

  uart_tx_byte #(.CLKS_PER_BIT(C), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld),
    .tx_rdy(tx_rdy), .txd(txd), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  int         m_t;
  int         m_frame_start;
  int         m_frame_end;
  logic [7:0] m_frame_byte;
  logic [7:0] m_hold;
  bit         m_hold_full;
  bit         m_ovr;

  task automatic model_reset();
    m_hold_full = 0;
    m_ovr       = 0;
    m_frame_end = m_t;
  endtask

  // Called once per rising edge with the inputs that edge samples.
  task automatic model_step();
    bit xf, acc;
    m_t++;
    xf  = m_hold_full && (m_t >= m_frame_end);
    acc = data_vld && (!m_hold_full || xf);
    if (data_vld && !acc) m_ovr = 1;
    if (xf) begin
      m_frame_byte  = m_hold;
      m_frame_start = m_t;
      m_frame_end   = m_t + 10 * C;
    end
    if (acc) begin
      m_hold      = data_in;
      m_hold_full = 1;
    end else if (xf) begin
      m_hold_full = 0;
    end
  endtask

  function automatic logic exp_txd();
    int b;
    if (m_t >= m_frame_end) return 1'b1;
    b = (m_t - m_frame_start) / C;
    if (b == 0) return 1'b0;
    if (b <= 8) return m_frame_byte[b-1];
    return 1'b1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, time %0t)", name, act, exp, m_t, $time);
    end
  endtask

  task automatic check_all();
    chk("txd", txd, exp_txd());
    chk("busy", busy, (m_t < m_frame_end));
    chk("tx_rdy", tx_rdy, !m_hold_full);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic strobe(input logic [7:0] d);
    data_in  = d;
    data_vld = 1'b1;
    step();
    data_vld = 1'b0;
    data_in  = 8'($urandom);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || !tx_rdy) && k < 1000) begin
      step();
      k++;
    end
    if (k >= 1000) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_timeout: busy=%0b tx_rdy=%0b after %0d cycles", busy, tx_rdy, k);
    end
  endtask

  // Send one byte from idle and capture each line level at the start of its
  // bit. Latency, frame shape and the return to idle are compared against
  // hand-computed constants.
  task automatic send_check(input logic [7:0] d, input logic [9:0] exp_line);
    logic [9:0] line;
    wait_idle();
    strobe(d);
    chk("latency_txd_high", txd, 1);
    chk("latency_rdy_low", tx_rdy, 0);
    step();
    chk("latency_fall", txd, 0);
    for (int b = 0; b < 10; b++) begin
      line[b] = txd;
      repeat (C) step();
    end
    chk("frame_line", line, exp_line);
    chk("frame_done_busy", busy, 0);
    chk("frame_done_rdy", tx_rdy, 1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] line;  // bit0 = start bit ... bit9 = stop bit
  } vec_t;

  vec_t vecs[6];

  // Simple byte-collector stand-in: produces a byte every few cycles, looks
  // at tx_rdy one cycle late, and never strobes twice in a row.
  task automatic run_collector(input int cycles);
    bit         rdy_prev = 1;
    int         cool = 0;
    int         gen = 3;
    bit         have = 0;
    logic [7:0] byte_q = '0;
    for (int i = 0; i < cycles; i++) begin
      if (have && rdy_prev && cool == 0) begin
        data_in  = byte_q;
        data_vld = 1'b1;
        have     = 0;
        cool     = 2;
      end else begin
        data_vld = 1'b0;
      end
      rdy_prev = tx_rdy;
      step();
      data_vld = 1'b0;
      if (cool > 0) cool--;
      if (!have) begin
        if (gen == 0) begin
          byte_q = 8'($urandom);
          have   = 1;
          gen    = $urandom_range(6, 30);
        end else begin
          gen--;
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bc;

    vecs[0] = '{8'hA5, 10'h34A};
    vecs[1] = '{8'h3C, 10'h278};
    vecs[2] = '{8'hFF, 10'h3FE};
    vecs[3] = '{8'h00, 10'h200};
    vecs[4] = '{8'h5A, 10'h2B4};
    vecs[5] = '{8'h81, 10'h302};

    rst = 1'b1; data_in = '0; data_vld = 1'b0;
    m_t = 0; m_frame_start = 0; m_frame_end = 0; m_frame_byte = '0; m_hold = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_rdy", tx_rdy, 1);
    chk("reset_ovr", overrun, 0);
    rst = 1'b0;
    step();

    // Single frames from idle.
    for (int i = 0; i < 6; i++) send_check(vecs[i].d, vecs[i].line);

    // Back-to-back: the second byte is strobed 3 clocks later while busy.
    wait_idle();
    strobe(8'h3C);
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 2) begin data_in = 8'hC3; data_vld = 1'b1; end
      step();
      data_vld = 1'b0;
      if (i == 2) chk("b2b_held", tx_rdy, 0);
      if (busy) bc++;
      else break;
    end
    chk("b2b_busy_cycles", bc, 80);

    // Overrun: 0x33 arrives while 0x22 is held and no transfer happens.
    wait_idle();
    strobe(8'h11);
    repeat (3) step();
    strobe(8'h22);
    step();
    strobe(8'h33);
    chk("ovr_set", overrun, 1);
    wait_idle();
    chk("ovr_sticky", overrun, 1);

    // A strobe on the edge where the held byte moves into the shifter.
    wait_idle();
    strobe(8'h3C);                 // edge N, transfer at N+1
    step();
    strobe(8'h44);                 // edge N+2, hold full
    repeat (38) step();            // edge N+40
    strobe(8'h5A);                 // edge N+41: last stop edge of 0x3C
    chk("simul_no_ovr", overrun, 1);  // still set from the overrun test
    chk("simul_hold_full", tx_rdy, 0);
    chk("simul_busy", busy, 1);
    wait_idle();

    // Reset mid-frame, during data bit 3 of 0xFF.
    strobe(8'hFF);
    repeat (1 + 4 * C + 1) step();
    chk("pre_rst_txd", txd, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rdy", tx_rdy, 1);
    chk("async_rst_ovr", overrun, 0);
    model_reset();
    #1 rst = 1'b0;
    send_check(8'h0F, 10'h21E);

    // Random strobes, including dropped ones.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        data_in  = 8'($urandom);
        data_vld = 1'b1;
      end
      step();
      data_vld = 1'b0;
    end
    wait_idle();

    // Collector-style traffic after a clean reset must never overrun.
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    #1 rst = 1'b0;
    run_collector(1500);
    wait_idle();
    chk("collector_no_ovr", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
